// File: rtl/adc_frame_to_fifo_pkg.sv
// Shared definitions for the ADC frame push sequencer.
package adc_frame_to_fifo_pkg;

  // Width of one ADC sample word as carried on the FIFO push interface.
  localparam int ADC_WORD_W = 32;

  // Sequencer states: idle, or walking through the words of the active frame.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  // Width of the word index for a frame of n words; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/adc_frame_skid.sv
// Single-entry frame holding register: absorbs one frame that arrives while
// the sequencer is still pushing the previous one.
module adc_frame_skid
  import adc_frame_to_fifo_pkg::*;
#(
  parameter int WORDS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        pop,
  input  logic [ADC_WORD_W*WORDS-1:0] din,
  output logic [ADC_WORD_W*WORDS-1:0] dout,
  output logic                        valid
);

  logic [ADC_WORD_W*WORDS-1:0] data_r;
  logic                        valid_r;

  // Hold register; a load in the same cycle as a pop refills the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {(ADC_WORD_W*WORDS){1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= din;
      valid_r <= 1'b1;
    end else if (pop) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign dout  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/adc_frame_to_fifo.sv
// Push sequencer: captures a packed ADC frame on a strobe and offers its
// leading words to the sample FIFO one per cycle, dropping words the FIFO
// cannot take. One overlapping frame is buffered; further ones are dropped.
module adc_frame_to_fifo
  import adc_frame_to_fifo_pkg::*;
#(
  parameter int WORDS_IN  = 10,
  parameter int WORDS_OUT = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_valid,
  input  logic [ADC_WORD_W*WORDS_IN-1:0] frame_words_packed,
  output logic                           push_valid,
  output logic [ADC_WORD_W-1:0]          push_data,
  input  logic                           push_ready,
  output logic                           busy,
  output logic                           frame_dropped
);

  localparam int            IW       = idx_width(WORDS_OUT);
  localparam int            FW       = ADC_WORD_W * WORDS_OUT;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_OUT - 1);

  seq_state_e            state_r, state_nxt_s;
  logic [IW-1:0]         idx_r, idx_nxt_s;
  logic [FW-1:0]         active_r, active_nxt_s;
  logic [ADC_WORD_W-1:0] push_data_r;
  logic                  dropped_r, dropped_nxt_s;
  logic                  skid_load_s, skid_pop_s, skid_valid_s;
  logic [FW-1:0]         skid_data_s;
  logic [FW-1:0]         frame_head_s;
  logic                  last_word_s;

  // Select word i of a packed frame.
  function automatic logic [ADC_WORD_W-1:0] word_at(input logic [FW-1:0] f,
                                                    input logic [IW-1:0] i);
    logic [ADC_WORD_W-1:0] r;
    r = {ADC_WORD_W{1'b0}};
    for (int w = 0; w < WORDS_OUT; w++) begin
      if (i == IW'(w)) begin
        r = f[ADC_WORD_W*w +: ADC_WORD_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Only the leading words of an incoming frame are ever pushed.
  assign frame_head_s = frame_words_packed[FW-1:0];
  assign last_word_s  = (idx_r == LAST_IDX);

  generate
    if (WORDS_IN > WORDS_OUT) begin : g_tail
      logic unused_tail_s;
      assign unused_tail_s = ^frame_words_packed[ADC_WORD_W*WORDS_IN-1:FW];
    end
  endgenerate

  adc_frame_skid #(
    .WORDS (WORDS_OUT)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load_s),
    .pop   (skid_pop_s),
    .din   (frame_head_s),
    .dout  (skid_data_s),
    .valid (skid_valid_s)
  );

  // Next-state logic: frame start, word stepping, skid hand-over and drops.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    active_nxt_s  = active_r;
    dropped_nxt_s = 1'b0;
    skid_load_s   = 1'b0;
    skid_pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_valid) begin
          active_nxt_s = frame_head_s;
          idx_nxt_s    = {IW{1'b0}};
          state_nxt_s  = ST_BUSY;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_word_s) begin
          idx_nxt_s = {IW{1'b0}};
          if (skid_valid_s) begin
            // Buffered frame follows with no gap; a new strobe refills the skid.
            active_nxt_s = skid_data_s;
            skid_pop_s   = 1'b1;
            skid_load_s  = frame_valid;
          end else if (frame_valid) begin
            active_nxt_s = frame_head_s;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          idx_nxt_s = idx_r + IW'(1);
          if (frame_valid) begin
            if (skid_valid_s) begin
              dropped_nxt_s = 1'b1;
            end else begin
              skid_load_s   = 1'b1;
            end
          end else begin
            dropped_nxt_s = 1'b0;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {IW{1'b0}};
      end
    endcase
  end

  // State, index, active frame and registered push outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IW{1'b0}};
      active_r    <= {FW{1'b0}};
      push_data_r <= {ADC_WORD_W{1'b0}};
      dropped_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      active_r    <= active_nxt_s;
      push_data_r <= (state_nxt_s == ST_BUSY) ? word_at(active_nxt_s, idx_nxt_s)
                                              : {ADC_WORD_W{1'b0}};
      dropped_r   <= dropped_nxt_s;
    end
  end

  assign busy          = (state_r == ST_BUSY);
  assign push_valid    = (state_r == ST_BUSY);
  assign push_data     = push_data_r;
  assign frame_dropped = dropped_r;

endmodule

// File: tb/tb_adc_frame_to_fifo.sv
// Scoreboard bench for adc_frame_to_fifo: expected words are queued as
// frames are issued; a monitor process pops and compares each offered word.
module tb_adc_frame_to_fifo;

  localparam int WI = 10;
  localparam int WO = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_valid;
  logic [32*WI-1:0] frame_words_packed;
  logic            push_valid;
  logic [31:0]     push_data;
  logic            push_ready;
  logic            busy;
  logic            frame_dropped;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          xfer_cnt = 0;
  int          busy_cnt = 0;
  int          drop_cnt = 0;

  adc_frame_to_fifo #(.WORDS_IN(WI), .WORDS_OUT(WO)) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_valid        (frame_valid),
    .frame_words_packed (frame_words_packed),
    .push_valid         (push_valid),
    .push_data          (push_data),
    .push_ready         (push_ready),
    .busy               (busy),
    .frame_dropped      (frame_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [31:0] base);
    for (int w = 0; w < WI; w++) frame_words_packed[32*w +: 32] = base + w;
  endtask

  task automatic expect_frame(input logic [31:0] base, input int n);
    for (int w = 0; w < n; w++) exp_q.push_back(base + w);
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (push_valid === 1'b1) begin
        busy_cnt++;
        if (push_ready === 1'b1) xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", push_data);
        end else begin
          check("push_data", push_data, exp_q.pop_front());
        end
        check("valid_vs_busy", {31'b0, push_valid}, {31'b0, busy});
      end
      if (frame_dropped === 1'b1) drop_cnt++;
    end
  endtask

  initial begin
    int x0, b0, d0, n;
    rst = 1'b1;
    frame_valid = 1'b0;
    push_ready = 1'b1;
    frame_words_packed = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (4) tick();
    check("rst_busy",       {31'b0, busy},          32'd0);
    check("rst_push_valid", {31'b0, push_valid},    32'd0);
    check("rst_push_data",  push_data,              32'd0);
    check("rst_dropped",    {31'b0, frame_dropped}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: single frame, FIFO always ready
    x0 = xfer_cnt; b0 = busy_cnt;
    load_frame(32'hA0000000);
    expect_frame(32'hA0000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    check("t1_busy_start", {31'b0, busy}, 32'd1);
    check("t1_word0",      push_data,     32'hA0000000);
    repeat (12) tick();
    check("t1_xfers",      xfer_cnt - x0, 32'd9);
    check("t1_busy_cyc",   busy_cnt - b0, 32'd9);
    check("t1_q_empty",    exp_q.size(),  32'd0);
    check("t1_busy_end",   {31'b0, busy}, 32'd0);

    // T2: FIFO full for words 0, 1 and 4
    x0 = xfer_cnt; b0 = busy_cnt;
    load_frame(32'hA0000000);
    expect_frame(32'hA0000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    for (int k = 0; k < WO; k++) begin
      push_ready = (k == 0 || k == 1 || k == 4) ? 1'b0 : 1'b1;
      tick();
    end
    push_ready = 1'b1;
    repeat (3) tick();
    check("t2_xfers",    xfer_cnt - x0, 32'd6);
    check("t2_busy_cyc", busy_cnt - b0, 32'd9);
    check("t2_q_empty",  exp_q.size(),  32'd0);
    check("t2_busy_end", {31'b0, busy}, 32'd0);

    // T3: three overlapping frames; second buffered, third dropped
    push_ready = 1'b0;
    b0 = busy_cnt; d0 = drop_cnt;
    load_frame(32'hC0000000);
    expect_frame(32'hC0000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    tick();
    load_frame(32'hD0000000);
    expect_frame(32'hD0000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    check("t3_no_drop_on_skid", drop_cnt - d0, 32'd0);
    tick();
    load_frame(32'hE0000000);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (3) tick();
    check("t3_drop_pulse", drop_cnt - d0, 32'd1);
    push_ready = 1'b1;
    repeat (25) tick();
    check("t3_busy_cyc",   busy_cnt - b0, 32'd18);
    check("t3_drop_total", drop_cnt - d0, 32'd1);
    check("t3_q_empty",    exp_q.size(),  32'd0);
    check("t3_busy_end",   {31'b0, busy}, 32'd0);

    // T4: new frame exactly on the last-word cycle, skid empty
    load_frame(32'h10000000);
    expect_frame(32'h10000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 2*WO; k++) begin
      if (busy === 1'b1) n++;
      if (k == WO-1) begin
        load_frame(32'h20000000);
        expect_frame(32'h20000000, WO);
        frame_valid = 1'b1;
      end
      tick();
      frame_valid = 1'b0;
    end
    check("t4_no_gap",   n,             32'd18);
    check("t4_busy_end", {31'b0, busy}, 32'd0);
    check("t4_q_empty",  exp_q.size(),  32'd0);

    // T5: reset at idx=4 with skid full
    d0 = drop_cnt;
    load_frame(32'h30000000);
    expect_frame(32'h30000000, 5);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    load_frame(32'h40000000);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (3) tick();
    check("t5_word4", push_data, 32'h30000004);
    rst = 1'b1; tick();
    check("t5_busy",       {31'b0, busy},          32'd0);
    check("t5_push_valid", {31'b0, push_valid},    32'd0);
    check("t5_push_data",  push_data,              32'd0);
    check("t5_dropped",    {31'b0, frame_dropped}, 32'd0);
    rst = 1'b0; tick();
    check("t5_q_empty", exp_q.size(),  32'd0);
    check("t5_no_drop", drop_cnt - d0, 32'd0);
    load_frame(32'h50000000);
    expect_frame(32'h50000000, WO);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    check("t5_restart_word0", push_data, 32'h50000000);
    repeat (12) tick();
    check("t5_end_q_empty", exp_q.size(),  32'd0);
    check("t5_busy_end",    {31'b0, busy}, 32'd0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
